// File: rtl/r7ocm_stream_pkg.sv
// Shared stream types and helpers for the R7-OCM Rx sample path.
// Pure declarations: no latency, no backpressure.
// Sign extension and I/Q word packing shared by the stream blocks.
package r7ocm_stream_pkg;

    localparam int STREAM_W = 32;

    typedef enum logic {IDLE, EMIT} pk_state_t;

    // Sign-extend the low iqw bits of sample to 16 bits.
    function automatic logic [15:0] sext16(input logic [15:0] sample, input int iqw);
        logic [15:0] r;
        r = '0;
        for (int b = 0; b < 16; b++)
            r[b] = (b < iqw) ? sample[b] : sample[4'(iqw - 1)];
        return r;
    endfunction

    function automatic logic [STREAM_W-1:0] pack_iq(input logic [15:0] i, input logic [15:0] q);
        return {q, i};
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with registered occupancy; head word is combinational.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push ignored when full, pop ignored when empty.
module stream_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclr,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // DEPTH is a power of two, so the level MSB alone means full.
    assign full    = level[AW];
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/iq_stream_packer.sv
// Packs enabled Rx channels' I/Q samples into 32-bit stream words via a FIFO.
// Latency: first word on s_data/s_valid two clocks after the rx_ce edge.
// Backpressure: s_ready pops the FIFO; full or overrun drops frames and counts them
// in ovf_cnt. Optional PACKER_TESTSRC_EN adds test_mode (counter data source).
module iq_stream_packer
    import r7ocm_stream_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int IQW        = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sclr,
    input  logic [NCH-1:0]                ch_mask,
    input  logic                          rx_ce,
    input  logic [NCH*IQW-1:0]            rx_i,
    input  logic [NCH*IQW-1:0]            rx_q,
    output logic [STREAM_W-1:0]           s_data,
    output logic                          s_first,
    output logic                          s_valid,
    input  logic                          s_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
`ifdef PACKER_TESTSRC_EN
    input  logic                          test_mode,
`endif
    output logic [CNT_W-1:0]              ovf_cnt
);

    pk_state_t            state;
    pk_state_t            state_nxt;
    logic [NCH*IQW-1:0]   snap_i;
    logic [NCH*IQW-1:0]   snap_q;
    logic [NCH-1:0]       rem_mask;
    logic [NCH-1:0]       cur_bit;
    logic                 frame_first;
    logic                 cap;
    logic                 fifo_push;
    logic                 overrun;
    logic                 drop;
    logic [STREAM_W-1:0]  iq_word;
    logic [STREAM_W-1:0]  push_word;
    logic [STREAM_W:0]    fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [1:0]           ovf_inc;
    logic [CNT_W:0]       ovf_sum;

`ifdef PACKER_TESTSRC_EN
    logic [STREAM_W-1:0]  tst_cnt;
    assign push_word = test_mode ? tst_cnt : iq_word;
`else
    assign push_word = iq_word;
`endif

    // Lowest remaining channel of the frame being emitted.
    assign cur_bit = rem_mask & (~rem_mask + NCH'(1));

    always_comb begin
        iq_word = '0;
        for (int k = 0; k < NCH; k++)
            if (cur_bit[k])
                iq_word = pack_iq(sext16(16'(snap_i[k*IQW +: IQW]), IQW),
                                  sext16(16'(snap_q[k*IQW +: IQW]), IQW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (sclr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        fifo_push = 1'b0;
        overrun   = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (rx_ce) begin
                    cap = 1'b1;
                    if (|ch_mask)
                        state_nxt = EMIT;
                end
            end
            EMIT: begin
                overrun = rx_ce;
                // A full FIFO abandons the remainder of the frame; the next
                // capture restarts with a first-flagged word.
                if (fifo_full) begin
                    drop      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    fifo_push = 1'b1;
                    if ((rem_mask & ~cur_bit) == '0)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ovf_inc = {1'b0, overrun} + {1'b0, drop};
    assign ovf_sum = {1'b0, ovf_cnt} + (CNT_W+1)'(ovf_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_i      <= '0;
            snap_q      <= '0;
            rem_mask    <= '0;
            frame_first <= 1'b0;
            ovf_cnt     <= '0;
        end else if (sclr) begin
            snap_i      <= '0;
            snap_q      <= '0;
            rem_mask    <= '0;
            frame_first <= 1'b0;
            ovf_cnt     <= '0;
        end else begin
            if (cap) begin
                snap_i      <= rx_i;
                snap_q      <= rx_q;
                rem_mask    <= ch_mask;
                frame_first <= 1'b1;
            end else if (fifo_push) begin
                rem_mask    <= rem_mask & ~cur_bit;
                frame_first <= 1'b0;
            end
            ovf_cnt <= ovf_sum[CNT_W] ? '1 : ovf_sum[CNT_W-1:0];
        end
    end

`ifdef PACKER_TESTSRC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tst_cnt <= '0;
        else if (sclr)
            tst_cnt <= '0;
        else if (fifo_push)
            tst_cnt <= tst_cnt + 1'b1;
    end
`endif

    stream_fifo #(
        .W     (STREAM_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclr     (sclr),
        .push     (fifo_push),
        .push_dat ({frame_first, push_word}),
        .pop      (s_ready),
        .pop_dat  (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign s_valid = ~fifo_empty;
    assign s_first = fifo_dout[STREAM_W];
    assign s_data  = fifo_dout[STREAM_W-1:0];

endmodule

// File: tb/tb_iq_stream_packer.sv
// Scoreboard bench for iq_stream_packer (NCH=2, IQW=12, FIFO_DEPTH=16, CNT_W=8).
module tb_iq_stream_packer;

    localparam int NCH   = 2;
    localparam int IQW   = 12;
    localparam int DEPTH = 16;
    localparam int CNT_W = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   sclr;
    logic [NCH-1:0]         ch_mask;
    logic                   rx_ce;
    logic [NCH*IQW-1:0]     rx_i;
    logic [NCH*IQW-1:0]     rx_q;
    logic [31:0]            s_data;
    logic                   s_first;
    logic                   s_valid;
    logic                   s_ready;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       ovf_cnt;
`ifdef PACKER_TESTSRC_EN
    logic                   test_mode;
`endif

    int n_chk = 0;
    int n_err = 0;
    int exp_ovf = 0;
    bit mon_en = 1'b0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    iq_stream_packer #(
        .NCH(NCH), .IQW(IQW), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclr(sclr), .ch_mask(ch_mask), .rx_ce(rx_ce),
        .rx_i(rx_i), .rx_q(rx_q), .s_data(s_data), .s_first(s_first),
        .s_valid(s_valid), .s_ready(s_ready), .level(level),
`ifdef PACKER_TESTSRC_EN
        .test_mode(test_mode),
`endif
        .ovf_cnt(ovf_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [32:0] model_word(input bit first, input logic [11:0] i, input logic [11:0] q);
        return {first, {{4{q[11]}}, q}, {{4{i[11]}}, i}};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle rx_ce; expected words (at most max_words of them) go to the scoreboard.
    task automatic send_frame(input logic [1:0] mask, input logic [23:0] iv,
                              input logic [23:0] qv, input int max_words);
        int n = 0;
        for (int k = 0; k < NCH; k++)
            if (mask[k] && n < max_words) begin
                sb.push_back(model_word(n == 0, iv[k*12 +: 12], qv[k*12 +: 12]));
                n++;
            end
        ch_mask = mask;
        rx_i    = iv;
        rx_q    = qv;
        rx_ce   = 1'b1;
        tick(1);
        rx_ce   = 1'b0;
    endtask

    task automatic rnd_frame(input logic [1:0] mask, input int max_words);
        send_frame(mask, 24'($urandom), 24'($urandom), max_words);
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            tick(1);
            t++;
        end
        tick(2);
        check_eq({tag, "_drain"}, 64'(sb.size()), 64'd0);
        check_eq({tag, "_no_extra"}, 64'(s_valid), 64'd0);
    endtask

    // Monitor: every accepted head word is compared against the scoreboard.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && s_valid && s_ready) begin
                check_eq("sb_pending", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("word", {31'd0, s_first, s_data}, 64'(e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sclr = 1'b0; ch_mask = '0; rx_ce = 1'b0;
        rx_i = '0; rx_q = '0; s_ready = 1'b0;
`ifdef PACKER_TESTSRC_EN
        test_mode = 1'b0;
`endif
        tick(3);
        check_eq("rst_valid", 64'(s_valid), 64'd0);
        check_eq("rst_first", 64'(s_first), 64'd0);
        check_eq("rst_data",  64'(s_data),  64'd0);
        check_eq("rst_level", 64'(level),   64'd0);
        check_eq("rst_ovf",   64'(ovf_cnt), 64'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick(2);

        // Basic two-channel frame with extreme sign cases and latency.
        s_ready = 1'b1;
        send_frame(2'b11, {12'h001, 12'h800}, {12'hFFF, 12'h7FF}, 2);
        check_eq("lat_cap_valid", 64'(s_valid), 64'd0);
        tick(1);
        check_eq("lat_push_valid", 64'(s_valid), 64'd1);
        check_eq("lat_data0", 64'(s_data), 64'h07FF_F800);
        check_eq("lat_first0", 64'(s_first), 64'd1);
        wait_drain("basic");
        check_eq("basic_ovf", 64'(ovf_cnt), 64'(exp_ovf));

        // Single upper channel, then an empty mask.
        send_frame(2'b10, {12'h5A5, 12'h123}, {12'h9C3, 12'h456}, 2);
        wait_drain("ch1_only");
        send_frame(2'b00, 24'hABCDEF, 24'h123456, 2);
        tick(4);
        check_eq("mask0_level", 64'(level), 64'd0);
        check_eq("mask0_ovf", 64'(ovf_cnt), 64'(exp_ovf));

        // Back-pressure fill: 8 frames fill the FIFO, the 9th is dropped.
        s_ready = 1'b0;
        for (int f = 0; f < 8; f++) begin
            rnd_frame(2'b11, 2);
            tick(3);
        end
        check_eq("fill_level", 64'(level), 64'(DEPTH));
        rnd_frame(2'b11, 0);
        tick(3);
        exp_ovf++;
        check_eq("full_level", 64'(level), 64'(DEPTH));
        check_eq("full_ovf", 64'(ovf_cnt), 64'(exp_ovf));
        check_eq("full_head", {31'd0, s_first, s_data}, 64'(sb[0]));
        s_ready = 1'b1;
        wait_drain("full");

        // Overrun: rx_ce on two consecutive cycles.
        ch_mask = 2'b11; rx_i = {12'h0F0, 12'h00F}; rx_q = {12'h111, 12'h222};
        sb.push_back(model_word(1'b1, 12'h00F, 12'h222));
        sb.push_back(model_word(1'b0, 12'h0F0, 12'h111));
        rx_ce = 1'b1;
        tick(1);
        rx_i = 24'hFFFFFF; rx_q = 24'hEEEEEE;
        tick(1);
        rx_ce = 1'b0;
        exp_ovf++;
        wait_drain("overrun");
        check_eq("overrun_ovf", 64'(ovf_cnt), 64'(exp_ovf));

        // Fill to DEPTH-1, then a two-channel frame is truncated mid-frame.
        s_ready = 1'b0;
        for (int f = 0; f < 7; f++) begin
            rnd_frame(2'b11, 2);
            tick(3);
        end
        rnd_frame(2'b01, 2);
        tick(3);
        check_eq("mid_pre_level", 64'(level), 64'(DEPTH - 1));
        rnd_frame(2'b11, 1);
        tick(3);
        exp_ovf++;
        check_eq("mid_level", 64'(level), 64'(DEPTH));
        check_eq("mid_ovf", 64'(ovf_cnt), 64'(exp_ovf));
        s_ready = 1'b1;
        tick(2);
        rnd_frame(2'b11, 2);
        wait_drain("mid");

        // Counter saturation: full FIFO plus a held strobe.
        s_ready = 1'b0;
        for (int f = 0; f < 8; f++) begin
            rnd_frame(2'b11, 2);
            tick(3);
        end
        ch_mask = 2'b11;
        rx_ce = 1'b1;
        tick(300);
        rx_ce = 1'b0;
        tick(2);
        check_eq("sat_ovf", 64'(ovf_cnt), 64'((1 << CNT_W) - 1));
        check_eq("sat_level", 64'(level), 64'(DEPTH));
        s_ready = 1'b1;
        wait_drain("sat");

        // Synchronous clear.
        sclr = 1'b1;
        tick(1);
        sclr = 1'b0;
        exp_ovf = 0;
        check_eq("sclr_ovf", 64'(ovf_cnt), 64'd0);
        check_eq("sclr_level", 64'(level), 64'd0);

`ifdef PACKER_TESTSRC_EN
        test_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            sb.push_back({1'b1, 32'(2*f)});
            sb.push_back({1'b0, 32'(2*f + 1)});
            ch_mask = 2'b11; rx_ce = 1'b1;
            tick(1);
            rx_ce = 1'b0;
            tick(3);
        end
        wait_drain("testsrc");
        test_mode = 1'b0;
`endif

        // Asynchronous reset in the middle of a frame.
        s_ready = 1'b0;
        rnd_frame(2'b11, 2);
        tick(1);
        check_eq("pre_rst_valid", 64'(s_valid), 64'd1);
        mon_en = 1'b0;
        sb.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(s_valid), 64'd0);
        check_eq("arst_first", 64'(s_first), 64'd0);
        check_eq("arst_data",  64'(s_data),  64'd0);
        check_eq("arst_level", 64'(level),   64'd0);
        check_eq("arst_ovf",   64'(ovf_cnt), 64'd0);
        tick(2);
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick(1);
        s_ready = 1'b1;
        rnd_frame(2'b01, 2);
        wait_drain("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
